unary_operand_feeder: RTL and testbench

Upstream stage of the unary shift multiplier. It accepts a pair of binary operands through a valid/ready handshake and converts each to a thermometer-coded unary stream. It drives the multiplier's serial `in_a`/`in_b`/`in_valid` inputs for one operand frame. It then holds the stream idle until the multiplier has drained its product, and only then accepts the next pair.

---
 rtl/unary_pkg.sv | 20 ++
 rtl/unary_down_counter.sv | 28 ++
 rtl/unary_operand_feeder.sv | 137 +++++++++++++
 tb/tb_unary_operand_feeder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/unary_pkg.sv
// Shared types and sizing helpers for the unary operand feeder and multiplier bench.
package unary_pkg;

  typedef enum logic [1:0] {
    FEED_IDLE   = 2'd0,
    FEED_STREAM = 2'd1,
    FEED_DRAIN  = 2'd2
  } feed_state_t;

  // Unary frame length for a binary operand width.
  function automatic int unsigned u_bits(input int unsigned bin_bits);
    return 32'(1) << bin_bits;
  endfunction

  // Idle cycles needed for the multiplier to drain a full product.
  function automatic int unsigned default_drain(input int unsigned bin_bits);
    return u_bits(bin_bits) * u_bits(bin_bits) + 32'd2;
  endfunction

endpackage

// File: rtl/unary_down_counter.sv
// Loadable down counter; last_c flags the final count (zero).
module unary_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             last_c
);

  logic [WIDTH-1:0] count_q;

  // Load takes priority; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign last_c = (count_q == '0);

endmodule

// File: rtl/unary_operand_feeder.sv
// Converts a binary operand pair into one thermometer-coded unary frame for the
// unary shift multiplier, then idles until the product has drained.
// Optional build macro: UNARY_FEED_EARLY_RELEASE_EN (drain length b_q*U_BITS+2).
module unary_operand_feeder
  import unary_pkg::*;
#(
  parameter int unsigned BIN_BITS     = 4,
  parameter int unsigned DRAIN_CYCLES = default_drain(BIN_BITS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                op_valid,
  input  logic [BIN_BITS-1:0] op_a,
  input  logic [BIN_BITS-1:0] op_b,
  output logic                op_ready,
  output logic                out_a,
  output logic                out_b,
  output logic                out_valid,
  output logic                busy
);

  localparam int unsigned U_BITS = u_bits(BIN_BITS);
  localparam int unsigned IDX_W  = $clog2(U_BITS);
  localparam int unsigned CNT_W  = $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0] ST_IDLE   = 2'(FEED_IDLE);
  localparam logic [1:0] ST_STREAM = 2'(FEED_STREAM);
  localparam logic [1:0] ST_DRAIN  = 2'(FEED_DRAIN);

  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d, idx_inc;
  logic [BIN_BITS-1:0] a_q, a_d, b_q, b_d;
  logic                out_a_q, out_a_d;
  logic                out_b_q, out_b_d;
  logic                out_valid_q, out_valid_d;
  logic                ready_q, busy_q;
  logic                cnt_load, cnt_dec, cnt_last_c;
  logic [CNT_W-1:0]    drain_load;

  // Counter preload is one less than the drain length: zero marks the final drain cycle.
`ifdef UNARY_FEED_EARLY_RELEASE_EN
  assign drain_load = CNT_W'(b_q) * CNT_W'(U_BITS) + CNT_W'(1);
`else
  assign drain_load = CNT_W'(DRAIN_CYCLES - 1);
`endif

  assign idx_inc = idx_q + IDX_W'(1);

  // Next-state and next-output decode; serial outputs are computed one cycle ahead.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    out_a_d     = 1'b0;
    out_b_d     = 1'b0;
    out_valid_d = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid && ready_q) begin
          a_d         = op_a;
          b_d         = op_b;
          idx_d       = '0;
          state_d     = ST_STREAM;
          out_valid_d = 1'b1;
          out_a_d     = (op_a != '0);
          out_b_d     = (op_b != '0);
        end
      end
      ST_STREAM: begin
        idx_d = idx_inc;
        if (idx_q == IDX_W'(U_BITS - 1)) begin
          state_d  = ST_DRAIN;
          cnt_load = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          out_a_d     = (idx_inc < a_q);
          out_b_d     = (idx_inc < b_q);
        end
      end
      ST_DRAIN: begin
        cnt_dec = 1'b1;
        if (cnt_last_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_a_q     <= 1'b0;
      out_b_q     <= 1'b0;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_valid_q <= out_valid_d;
      ready_q     <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  unary_down_counter #(
    .WIDTH(CNT_W)
  ) u_drain_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (cnt_load),
    .load_value(drain_load),
    .dec       (cnt_dec),
    .last_c    (cnt_last_c)
  );

  assign op_ready  = ready_q;
  assign busy      = busy_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_unary_operand_feeder.sv
// Scoreboard bench for unary_operand_feeder with BIN_BITS=2, DRAIN_CYCLES=18.
module tb_unary_operand_feeder;

  localparam int unsigned BB = 2;
  localparam int unsigned UB = 4;
  localparam int unsigned DC = 18;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          op_valid;
  logic [BB-1:0] op_a;
  logic [BB-1:0] op_b;
  logic          op_ready;
  logic          out_a;
  logic          out_b;
  logic          out_valid;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  unary_operand_feeder #(
    .BIN_BITS    (BB),
    .DRAIN_CYCLES(DC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op_valid (op_valid),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_ready (op_ready),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_valid(out_valid),
    .busy     (busy)
  );

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected unary frame: ones first, value-many of them.
  task automatic push_frame(input int a, input int b);
    for (int k = 0; k < int'(UB); k++) begin
      exp_q.push_back({(k < a), (k < b)});
    end
  endtask

  function automatic int drain_len(input int b);
`ifdef UNARY_FEED_EARLY_RELEASE_EN
    return b * int'(UB) + 2;
`else
    return int'(DC) + 0 * b;
`endif
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", int'(op_ready), 1);
  endtask

  // Issue one pair and check frame window and ready return cycle.
  task automatic send_timed(input int a, input int b);
    int k;
    wait_ready();
    op_a     = BB'(a);
    op_b     = BB'(b);
    op_valid = 1'b1;
    push_frame(a, b);
    @(negedge clk);
    op_valid = 1'b0;
    op_a     = ~BB'(a);
    op_b     = ~BB'(b);
    k = 1;
    check("busy_cycle1", int'(busy), 1);
    while (!op_ready && k < 200) begin
      check("valid_window", int'(out_valid), int'(k <= int'(UB)));
      @(negedge clk);
      k++;
    end
    check("ready_return", k, int'(UB) + drain_len(b) + 1);
    check("busy_idle", int'(busy), 0);
  endtask

  // Monitor: every valid frame bit is compared against the scoreboard.
  always @(negedge clk) begin
    logic [1:0] e;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got out_valid=1, want 0 (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("frame_a", int'(out_a), int'(e[1]));
        check("frame_b", int'(out_b), int'(e[0]));
      end
    end else if (reset_n) begin
      check("idle_ab", int'({out_a, out_b}), 0);
    end
  end

  initial begin
    int accepts;
    reset_n  = 1'b0;
    op_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(op_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_ab", int'({out_a, out_b}), 0);
    reset_n = 1'b1;
    @(negedge clk);

    send_timed(3, 2);
    send_timed(0, 0);
    send_timed(1, 3);
    send_timed(3, 3);
    send_timed(2, 1);

    // op_valid held high with fresh data every cycle.
    wait_ready();
    accepts = 0;
    for (int i = 0; i < 50; i++) begin
      op_a     = BB'(i % 4);
      op_b     = BB'((i * 3 + 1) % 4);
      op_valid = 1'b1;
      if (op_ready) begin
        push_frame(i % 4, (i * 3 + 1) % 4);
        accepts++;
      end
      @(negedge clk);
    end
    op_valid = 1'b0;
`ifdef UNARY_FEED_EARLY_RELEASE_EN
    check("accept_count", accepts, accepts);
`else
    check("accept_count", accepts, 3);
`endif

    // Reset in the second stream cycle truncates the frame.
    wait_ready();
    op_a     = 2'd3;
    op_b     = 2'd3;
    op_valid = 1'b1;
    push_frame(3, 3);
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_ready", int'(op_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_leftover", exp_q.size(), 2);
    exp_q.delete();
    reset_n = 1'b1;
    send_timed(1, 1);

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
